jtag_tap_multi: RTL and testbench

- Parametrised IEEE 1149.1 TAP controller; successor to the single-DMI TAP in the debug module.
- Provides IDCODE and BYPASS plus `NumUserDr` user data-register channels, each selected by a configurable IR opcode.
- Exports capture/shift/update strobes to external DR logic, such as the DTMCS and DMI registers.
- Sits between the JTAG pads and `dmi_jtag`, and proper TestLogicReset semantics are implemented.

---
 rtl/jtag_tap_multi.sv | 236 +++++++++++++++++++++++
 tb/tb_jtag_tap_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_multi
// Purpose  : IEEE 1149.1 TAP controller with IDCODE, BYPASS and NumUserDr
//            user DR channels selected by configurable IR opcodes. Exports
//            capture/shift/update strobes for external DR logic.
// Options  : define JTAG_TAP_USERCODE_EN to add a 32-bit USERCODE register.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_multi #(
  parameter int unsigned                        IrLength      = 5,
  parameter int unsigned                        NumUserDr     = 2,
  parameter logic [31:0]                        IdcodeValue   = 32'h00000001,
  parameter logic [NumUserDr-1:0][IrLength-1:0] UserIr        = {5'h11, 5'h10},
  parameter logic [IrLength-1:0]                UsercodeIr    = 5'h03,
  parameter logic [31:0]                        UsercodeValue = 32'h0
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 tms_i,
  input  logic                 td_i,
  output logic                 td_o,
  output logic                 tdo_oe_o,
  input  logic                 testmode_i,
  output logic                 tck_o,
  output logic                 tdi_o,
  output logic                 trst_no,
  output logic                 capture_o,
  output logic                 shift_o,
  output logic                 update_o,
  output logic [NumUserDr-1:0] user_select_o,
  input  logic [NumUserDr-1:0] user_tdo_i,
  output logic [IrLength-1:0]  ir_o
);

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle,
    SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr,
    SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  localparam logic [IrLength-1:0] IdcodeIr  = IrLength'(1);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(2'b01);

  tap_state_e state_q, state_d;

  logic [IrLength-1:0]  ir_q, ir_d;
  logic [IrLength-1:0]  ir_shift_q, ir_shift_d;
  logic                 bypass_q, bypass_d;
  logic [31:0]          idcode_q, idcode_d;
  logic                 tdo_q, tdo_d;
  logic                 tdo_oe_q, tdo_oe_d;

  logic                 in_tlr;
  logic                 sel_idcode;
  logic [NumUserDr-1:0] user_sel;
  logic                 tdo_mux;
  logic                 tck_n;
  logic                 tck_tdo;

`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0]          usercode_q, usercode_d;
  logic                 sel_usercode;
`else
  logic                 unused_usercode;
  assign unused_usercode = ^{UsercodeIr, UsercodeValue};
`endif

  // Pad feed-throughs and strobes decoded straight from the state register
  assign tck_o         = tck_i;
  assign tdi_o         = td_i;
  assign trst_no       = trst_ni & (state_q != TestLogicReset);
  assign capture_o     = (state_q == CaptureDr);
  assign shift_o       = (state_q == ShiftDr);
  assign update_o      = (state_q == UpdateDr);
  assign user_select_o = user_sel;
  assign ir_o          = ir_q;
  assign td_o          = tdo_q;
  assign tdo_oe_o      = tdo_oe_q;

  // TDO launch clock: inverter plus 2:1 clock mux, testmode picks raw TCK
  assign tck_n   = ~tck_i;
  assign tck_tdo = testmode_i ? tck_i : tck_n;

  // TAP state register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  // Standard 1149.1 next-state function on TMS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // Also load on the edge entering TestLogicReset so IR reads IDCODE as
  // soon as the controller lands there, not one TCK later.
  assign in_tlr = (state_q == TestLogicReset) || (state_d == TestLogicReset);

  // IR capture/shift/update
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    if (in_tlr)                    ir_d = IdcodeIr;
    else if (state_q == UpdateIr)  ir_d = ir_shift_q;
    if (state_q == CaptureIr)      ir_shift_d = IrCapture;
    else if (state_q == ShiftIr)   ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
  end

  // IR registers
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q       <= IdcodeIr;
      ir_shift_q <= '0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
    end
  end

  // Fixed-priority instruction decode; lowest user channel wins on duplicates
  always_comb begin
    sel_idcode = 1'b0;
    user_sel   = '0;
`ifdef JTAG_TAP_USERCODE_EN
    sel_usercode = 1'b0;
`endif
    if (ir_q == '0 || ir_q == '1) begin
      sel_idcode = 1'b0;
    end else if (ir_q == IdcodeIr) begin
      sel_idcode = 1'b1;
`ifdef JTAG_TAP_USERCODE_EN
    end else if (ir_q == UsercodeIr) begin
      sel_usercode = 1'b1;
`endif
    end else begin
      for (int k = NumUserDr - 1; k >= 0; k--) begin
        if (ir_q == UserIr[k]) begin
          user_sel    = '0;
          user_sel[k] = 1'b1;
        end
      end
    end
  end

  // Internal DRs: captured in reset/CaptureDr, shifted right in ShiftDr
  always_comb begin
    bypass_d = bypass_q;
    idcode_d = idcode_q;
`ifdef JTAG_TAP_USERCODE_EN
    usercode_d = usercode_q;
`endif
    if (in_tlr || state_q == CaptureDr) begin
      bypass_d = 1'b0;
      idcode_d = IdcodeValue;
`ifdef JTAG_TAP_USERCODE_EN
      usercode_d = UsercodeValue;
`endif
    end else if (state_q == ShiftDr) begin
      bypass_d = td_i;
      idcode_d = {td_i, idcode_q[31:1]};
`ifdef JTAG_TAP_USERCODE_EN
      usercode_d = {td_i, usercode_q[31:1]};
`endif
    end
  end

  // DR registers
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      bypass_q <= 1'b0;
      idcode_q <= IdcodeValue;
`ifdef JTAG_TAP_USERCODE_EN
      usercode_q <= UsercodeValue;
`endif
    end else begin
      bypass_q <= bypass_d;
      idcode_q <= idcode_d;
`ifdef JTAG_TAP_USERCODE_EN
      usercode_q <= usercode_d;
`endif
    end
  end

  // TDO source select: IR LSB during ShiftIr, otherwise the selected DR
  always_comb begin
    tdo_mux = bypass_q;
    if (state_q == ShiftIr) begin
      tdo_mux = ir_shift_q[0];
    end else if (sel_idcode) begin
      tdo_mux = idcode_q[0];
`ifdef JTAG_TAP_USERCODE_EN
    end else if (sel_usercode) begin
      tdo_mux = usercode_q[0];
`endif
    end else begin
      for (int k = 0; k < NumUserDr; k++) begin
        if (user_sel[k]) tdo_mux = user_tdo_i[k];
      end
    end
    tdo_d    = tdo_mux;
    tdo_oe_d = (state_q == ShiftIr) || (state_q == ShiftDr);
  end

  // TDO and its enable launch on the falling edge of TCK
  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_multi
// Purpose  : Scoreboard bench for jtag_tap_multi. Scan tasks queue the
//            expected TDO bits; a monitor pops one per shift cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_multi;
  localparam int IrLength  = 5;
  localparam int NumUserDr = 2;

  logic                 tck_i = 1'b0;
  logic                 trst_ni = 1'b0;
  logic                 tms_i = 1'b1;
  logic                 td_i = 1'b0;
  logic                 testmode_i = 1'b0;
  logic [NumUserDr-1:0] user_tdo_i = '0;
  logic                 td_o, tdo_oe_o, tck_o, tdi_o, trst_no;
  logic                 capture_o, shift_o, update_o;
  logic [NumUserDr-1:0] user_select_o;
  logic [IrLength-1:0]  ir_o;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic mon_exp;

  jtag_tap_multi #(
    .IrLength      (IrLength),
    .NumUserDr     (NumUserDr),
    .IdcodeValue   (32'h00000001),
    .UserIr        ({5'h11, 5'h10}),
    .UsercodeIr    (5'h03),
    .UsercodeValue (32'hCAFEF00D)
  ) dut (
    .tck_i         (tck_i),
    .trst_ni       (trst_ni),
    .tms_i         (tms_i),
    .td_i          (td_i),
    .td_o          (td_o),
    .tdo_oe_o      (tdo_oe_o),
    .testmode_i    (testmode_i),
    .tck_o         (tck_o),
    .tdi_o         (tdi_o),
    .trst_no       (trst_no),
    .capture_o     (capture_o),
    .shift_o       (shift_o),
    .update_o      (update_o),
    .user_select_o (user_select_o),
    .user_tdo_i    (user_tdo_i),
    .ir_o          (ir_o)
  );

  // TCK, 10 time-unit period
  always #5 tck_i = ~tck_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge with TDO enabled must match the next queued bit
  always @(negedge tck_i) begin
    #1;
    if (tdo_oe_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tdo_unexpected: got %b with nothing expected", td_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (td_o !== mon_exp) begin
          failures++;
          $display("FAIL tdo_bit: got %b expected %b", td_o, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // One TCK: drive TMS/TDI, then settle just after the falling edge
  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck_i);
    @(negedge tck_i);
    #2;
  endtask

  // IR scan from RunTestIdle back to RunTestIdle; captured pattern is 0...01
  task automatic ir_scan(input logic [IrLength-1:0] val);
    logic [IrLength-1:0] cap;
    cap = IrLength'(1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(cap[0]);
    step(1'b0, 1'b0);
    for (int i = 0; i < IrLength; i++) begin
      if (i < IrLength - 1) exp_q.push_back(cap[i+1]);
      step(i == IrLength - 1, val[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_after_update", 32'(ir_o), 32'(val));
  endtask

  // n-bit DR scan from RunTestIdle; usr drives user_tdo_i[1] bit by bit
  task automatic dr_scan(input int n, input logic [63:0] tdi, input logic [63:0] exp,
                         input logic [63:0] usr, input string tag);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk({tag, "_capture"}, 32'(capture_o), 32'd1);
    user_tdo_i[1] = usr[0];
    exp_q.push_back(exp[0]);
    step(1'b0, 1'b0);
    chk({tag, "_shift"}, 32'({capture_o, shift_o}), 32'b01);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) begin
        user_tdo_i[1] = usr[i+1];
        exp_q.push_back(exp[i+1]);
      end
      step(i == n - 1, tdi[i]);
    end
    step(1'b1, 1'b0);
    chk({tag, "_update"}, 32'({shift_o, update_o}), 32'b01);
    step(1'b0, 1'b0);
    chk({tag, "_idle"}, 32'({capture_o, shift_o, update_o}), 32'b000);
  endtask

  // Directed test sequence
  initial begin
    #12;
    chk("rst_td_o", 32'(td_o), 32'd0);
    chk("rst_tdo_oe", 32'(tdo_oe_o), 32'd0);
    chk("rst_ir", 32'(ir_o), 32'd1);
    chk("rst_user_sel", 32'(user_select_o), 32'd0);
    chk("rst_strobes", 32'({capture_o, shift_o, update_o}), 32'd0);
    chk("rst_trst_no", 32'(trst_no), 32'd0);
    #10 trst_ni = 1'b1;
    step(1'b1, 1'b0);
    chk("tlr_trst_no", 32'(trst_no), 32'd0);
    step(1'b0, 1'b0);
    chk("rti_trst_no", 32'(trst_no), 32'd1);

    // IDCODE scan with default IR
    dr_scan(32, 64'h0, 64'h1, 64'h0, "idcode");
    chk("idcode_ir", 32'(ir_o), 32'd1);
    chk("idcode_user_sel", 32'(user_select_o), 32'd0);

    // User channel 1, TDO follows user_tdo_i[1]
    ir_scan(5'h11);
    chk("user1_select", 32'(user_select_o), 32'b10);
    dr_scan(8, 64'h0, 64'hB2, 64'hB2, "user1");

    // User channel 0
    ir_scan(5'h10);
    chk("user0_select", 32'(user_select_o), 32'b01);

    // All-ones BYPASS: leading 0 then TDI delayed one TCK
    ir_scan(5'h1f);
    chk("bypass1_select", 32'(user_select_o), 32'd0);
    dr_scan(9, 64'h0A5, 64'h14A, 64'h0, "bypass1");

    // All-zeros BYPASS
    ir_scan(5'h00);
    dr_scan(2, 64'h1, 64'h2, 64'h0, "bypass0");

    // Five TMS=1 from ShiftDr reach TestLogicReset
    ir_scan(5'h11);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    user_tdo_i[1] = 1'b1;
    exp_q.push_back(1'b1);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    chk("tms5_ir", 32'(ir_o), 32'd1);
    chk("tms5_trst_no", 32'(trst_no), 32'd0);
    chk("tms5_user_sel", 32'(user_select_o), 32'd0);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of ShiftIr
    ir_scan(5'h11);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    step(1'b0, 1'b0);
    #1 trst_ni = 1'b0;
    #1;
    chk("arst_td_o", 32'(td_o), 32'd0);
    chk("arst_tdo_oe", 32'(tdo_oe_o), 32'd0);
    chk("arst_ir", 32'(ir_o), 32'd1);
    chk("arst_user_sel", 32'(user_select_o), 32'd0);
    chk("arst_trst_no", 32'(trst_no), 32'd0);
    tms_i = 1'b1;
    @(negedge tck_i);
    #2 trst_ni = 1'b1;
    step(1'b0, 1'b0);
    chk("arst_ir_after", 32'(ir_o), 32'd1);
    chk("arst_user_sel_after", 32'(user_select_o), 32'd0);

    // USERCODE opcode
    ir_scan(5'h03);
`ifdef JTAG_TAP_USERCODE_EN
    dr_scan(32, 64'h0, 64'hCAFEF00D, 64'h0, "usercode");
`else
    dr_scan(2, 64'h1, 64'h2, 64'h0, "usercode_bypass");
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
